// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing constants and types for the register scoreboard.
package reg_scoreboard_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = 3;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/sb_counter.sv
// Outstanding-write counter for one architectural register.
// clr wins over everything; inc and dec together cancel; the count
// saturates at both ends instead of wrapping.
module sb_counter
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output cnt_t count,
    output logic nonzero
);

    // Count update with flush priority and saturation at 0 and CNT_MAX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != CNT_W'(CNT_MAX)) count <= count + cnt_t'(1);
        end else if (dec && !inc) begin
            if (count != '0) count <= count - cnt_t'(1);
        end
    end

    assign nonzero = |count;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writes for registers 1..31,
// stalls decode on RAW hazards or a full destination counter, and flags
// write-backs that have no matching outstanding issue.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rs,
    input  logic [ADDR_W-1:0]   issue_rt,
    input  logic                issue_uses_rt,
    input  logic                issue_we,
    input  logic [ADDR_W-1:0]   issue_dst,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_dst,
    input  logic                flush,
    output logic                stall,
    output logic                issue_fire,
    output logic [NUM_REGS-1:0] pending,
    output logic                err_underflow
);

    cnt_t                counts [NUM_REGS];
    logic [NUM_REGS-1:0] nonzero;
    logic                rs_busy;
    logic                rt_busy;
    logic                dst_full;
    logic                issue_inc;
    logic                wb_hit;
    logic                underflow;

    // A source stays busy unless its last outstanding write retires this cycle
    function automatic logic src_busy(input cnt_t c, input reg_addr_t src,
                                      input logic wv, input reg_addr_t wd);
        return (c != '0) && !((c == cnt_t'(1)) && wv && (wd == src));
    endfunction

    // Register 0 is hardwired: never counted, never pending
    assign counts[0]  = '0;
    assign nonzero[0] = 1'b0;

    assign rs_busy    = src_busy(counts[issue_rs], issue_rs, wb_valid, wb_dst);
    assign rt_busy    = src_busy(counts[issue_rt], issue_rt, wb_valid, wb_dst);
    assign dst_full   = issue_we && (counts[issue_dst] == CNT_W'(CNT_MAX));

    assign stall      = issue_valid && (rs_busy || (issue_uses_rt && rt_busy) || dst_full);
    assign issue_fire = issue_valid && !stall && !flush;

    assign issue_inc  = issue_fire && issue_we;
    assign wb_hit     = wb_valid;

    // Write-back to an idle register is an error unless an issue to the
    // same register cancels it this cycle; a flushing cycle discards it.
    assign underflow  = wb_valid && !flush && (wb_dst != '0) &&
                        (counts[wb_dst] == '0) &&
                        !(issue_inc && (issue_dst == wb_dst));

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic inc;
        logic dec;
        assign inc = issue_inc && (issue_dst == ADDR_W'(i));
        assign dec = wb_hit && (wb_dst == ADDR_W'(i));
        sb_counter u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc),
            .dec     (dec),
            .clr     (flush),
            .count   (counts[i]),
            .nonzero (nonzero[i])
        );
    end

    assign pending = nonzero;

    // Sticky underflow flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (underflow) begin
            err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: the driver applies one cycle of stimulus, computes the
// expected outputs from a counts-array reference model and queues them; the
// monitor pops and compares on every falling edge.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_uses_rt;
    logic        issue_we;
    logic [4:0]  issue_dst;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic        flush;
    logic        stall;
    logic        issue_fire;
    logic [31:0] pending;
    logic        err_underflow;

    reg_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rt      (issue_rt),
        .issue_uses_rt (issue_uses_rt),
        .issue_we      (issue_we),
        .issue_dst     (issue_dst),
        .wb_valid      (wb_valid),
        .wb_dst        (wb_dst),
        .flush         (flush),
        .stall         (stall),
        .issue_fire    (issue_fire),
        .pending       (pending),
        .err_underflow (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit        stall;
        bit        fire;
        bit [31:0] pend;
        bit        err;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: plain outstanding-write counts per register
    int mcnt [32];
    bit merr;

    function automatic bit m_busy(input int r, input bit wv, input int wd);
        if (r == 0 || mcnt[r] == 0) return 1'b0;
        if (mcnt[r] == 1 && wv && wd == r) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cyc(input bit r, input bit v, input int rs, input int rt,
                       input bit urt, input bit we, input int dst,
                       input bit wv, input int wd, input bit fl);
        exp_t e;
        bit   inc;
        bit   wbh;
        @(posedge clk);
        #1;
        rst = r; issue_valid = v; issue_rs = 5'(rs); issue_rt = 5'(rt);
        issue_uses_rt = urt; issue_we = we; issue_dst = 5'(dst);
        wb_valid = wv; wb_dst = 5'(wd); flush = fl;
        if (r) begin
            for (int k = 0; k < 32; k++) mcnt[k] = 0;
            merr = 1'b0;
        end
        e.stall = v && (m_busy(rs, wv, wd) || (urt && m_busy(rt, wv, wd)) ||
                        (we && dst != 0 && mcnt[dst] == 3));
        e.fire  = v && !e.stall && !fl;
        e.pend  = '0;
        for (int k = 1; k < 32; k++) e.pend[k] = (mcnt[k] != 0);
        e.err   = merr;
        expq.push_back(e);
        if (!r) begin
            if (fl) begin
                for (int k = 0; k < 32; k++) mcnt[k] = 0;
            end else begin
                inc = e.fire && we && dst != 0;
                wbh = wv && wd != 0;
                if (!(inc && wbh && dst == wd)) begin
                    if (inc) mcnt[dst]++;
                    if (wbh) begin
                        if (mcnt[wd] > 0) mcnt[wd]--;
                        else merr = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input int rs, input int dst);
        cyc(0, 1, rs, 0, 0, 1, dst, 0, 0, 0);
    endtask

    task automatic wb(input int wd);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, wd, 0);
    endtask

    // Monitor: compare every queued expectation against the DUT outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                n_checks++;
                if (stall !== e.stall) begin
                    n_fail++;
                    $display("FAIL stall @%0t: got %b expected %b", $time, stall, e.stall);
                end
                n_checks++;
                if (issue_fire !== e.fire) begin
                    n_fail++;
                    $display("FAIL issue_fire @%0t: got %b expected %b", $time, issue_fire, e.fire);
                end
                n_checks++;
                if (pending !== e.pend) begin
                    n_fail++;
                    $display("FAIL pending @%0t: got %h expected %h", $time, pending, e.pend);
                end
                n_checks++;
                if (err_underflow !== e.err) begin
                    n_fail++;
                    $display("FAIL err_underflow @%0t: got %b expected %b", $time, err_underflow, e.err);
                end
            end
        end
    end

    // Driver: reset, directed scenarios, then randomized traffic
    initial begin
        int rs, rt, dst, wd;
        bit v, urt, we, wv, fl, r;
        rst = 1'b1; issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_uses_rt = 0;
        issue_we = 0; issue_dst = 0; wb_valid = 0; wb_dst = 0; flush = 0;
        merr = 1'b0;
        for (int k = 0; k < 32; k++) mcnt[k] = 0;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Issue and write-back to an idle register in the same cycle: no error
        cyc(0, 1, 0, 0, 0, 1, 14, 1, 14, 0);
        idle();

        // RAW hazard on r8 and write-back bypass
        issue(0, 8);
        cyc(0, 1, 8, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 8, 0, 0, 0, 0, 1, 8, 0);
        idle();
        cyc(0, 1, 0, 8, 1, 0, 0, 0, 0, 0);

        // Saturate r5 at three outstanding writes
        issue(0, 5); issue(0, 5); issue(0, 5);
        issue(0, 5);
        cyc(0, 1, 0, 0, 0, 1, 5, 1, 5, 0);
        issue(0, 5);
        wb(5); wb(5); wb(5);
        idle();

        // Register 0 never tracked
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 1, 1, 0, 1, 0, 0);
        idle();

        // Simultaneous issue and write-back on r12, then underflow on r20
        issue(0, 12);
        cyc(0, 1, 0, 0, 0, 1, 12, 1, 12, 0);
        idle();
        wb(12);
        idle();
        wb(20);
        idle(); idle();

        // Flush with several pending registers
        issue(0, 3); issue(0, 7); issue(0, 31);
        cyc(0, 1, 0, 0, 0, 1, 4, 1, 3, 1);
        cyc(0, 1, 3, 7, 1, 1, 31, 0, 0, 1);
        idle();

        // Reset mid-operation, then stale write-back
        issue(0, 9); issue(0, 10);
        cyc(1, 1, 9, 10, 1, 1, 9, 0, 0, 0);
        idle();
        wb(9);
        idle();

        // Randomized traffic over a small register window to force hazards
        for (int n = 0; n < 1500; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            v   = $urandom_range(0, 1);
            urt = $urandom_range(0, 1);
            we  = ($urandom_range(0, 3) != 0);
            rs  = $urandom_range(0, 7);
            rt  = $urandom_range(0, 7);
            dst = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            wv  = $urandom_range(0, 1);
            wd  = $urandom_range(0, 7);
            for (int t = 0; t < 4; t++) begin
                if (mcnt[wd] == 0 && $urandom_range(0, 9) != 0) wd = $urandom_range(0, 7);
            end
            cyc(r, v, rs, rt, urt, we, dst, wv, wd, fl);
        end
        idle();

        for (int k = 0; k < 10 && expq.size() != 0; k++) @(posedge clk);
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued expectations, expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  decode stage presents an instruction
- issue_rs  in  5  source register A
- issue_rt  in  5  source register B
- issue_uses_rt  in  1  source B is read
- issue_we  in  1  instruction writes a register
- issue_dst  in  5  destination register (output of the rt/rd select mux)
- wb_valid  in  1  write-back stage retires a register write
- wb_dst  in  5  register written back
- flush  in  1  discard all outstanding writes
- stall  out  1  decode must hold
- issue_fire  out  1  instruction accepted this cycle
- pending  out  32  bit i = register i has an outstanding write
- err_underflow  out  1  sticky: write-back to a non-pending register

Function
REQ-003 Each register 1..31 SHALL hold a 2-bit outstanding-write count; register 0 SHALL never be pending and SHALL ignore issue and write-back.
REQ-004 pending[i] SHALL be 1 exactly when count[i] != 0; pending[0] SHALL be constant 0.
REQ-005 stall SHALL be combinational: issue_valid AND (rs_busy OR (issue_uses_rt AND rt_busy) OR (issue_we AND count[issue_dst]==3)).
REQ-006 A source is busy when its count is non-zero, except when count==1 and wb_valid with wb_dst equal to that source in the same cycle (write-back bypass); then it is not busy.
REQ-007 issue_fire SHALL equal issue_valid AND NOT stall AND NOT flush.
REQ-008 On issue_fire with issue_we and issue_dst != 0, count[issue_dst] SHALL increment at the next clock edge; pending SHALL be visible one cycle after issue.
REQ-009 On wb_valid with wb_dst != 0 and count[wb_dst] != 0, that count SHALL decrement at the next clock edge.
REQ-010 Issue and write-back to the same register in one cycle SHALL leave its count unchanged.
REQ-011 wb_valid to a register whose count is 0 (and no simultaneous issue to it) SHALL leave the count at 0 and set err_underflow, which stays 1 until reset.
REQ-012 Count SHALL never wrap: 3 saturates via stall (REQ-005), 0 via REQ-011.
REQ-013 flush SHALL clear all counts at the next edge and take priority over issue and write-back in the same cycle; stall SHALL still evaluate combinationally during flush.
REQ-014 Any number of distinct registers MAY be pending simultaneously; updates to different registers in the same cycle are independent.

Reset
REQ-015 rst SHALL immediately clear all counts, pending=0, err_underflow=0; stall and issue_fire then follow REQ-005/REQ-007 from the cleared state.
REQ-016 rst asserted mid-operation SHALL discard all outstanding writes; write-backs after reset deassertion for pre-reset issues SHALL set err_underflow.

Structure
REQ-017 A shared package reg_scoreboard_pkg SHALL hold NUM_REGS=32, ADDR_W=5, CNT_W=2, CNT_MAX=3.
REQ-018 Per-register counting SHALL be a sub-module sb_counter (inc, dec, clr, count, nonzero), instantiated for registers 1..31.

Verification
REQ-019 Issue dst=8 (we=1), next cycle issue rs=8 -> stall=1, pending[8]=1; wb_dst=8 -> same-cycle stall=0 (bypass), count[8]=0 next cycle.
REQ-020 Three issues to dst=5 with no write-back -> count[5]=3; fourth issue writing 5 -> stall=1, issue_fire=0; one wb_dst=5 -> next-cycle stall=0.
REQ-021 Issue dst=0 and wb_dst=0 repeatedly -> pending=0, err_underflow=0, stall never caused by register 0.
REQ-022 count[12]=1, same-cycle issue dst=12 and wb_dst=12 -> count[12] stays 1; wb_dst=20 with count 0 -> err_underflow=1, sticky.
REQ-023 Registers 3,7,31 pending, flush=1 with issue_valid -> issue_fire=0, pending=0 next cycle.
REQ-024 rst pulse while registers 9 and 10 pending -> pending=0 immediately; later wb_dst=9 -> err_underflow=1.
